spi_xfer_ctrl: RTL and testbench

- Transaction sequencer directly upstream of the byte-level SPI master core.
- Accepts a command (slave index, byte count), drives the slave-select lines with programmable setup/hold times, and feeds TX bytes to the core one at a time.
- Returns each received byte on an RX valid/ready stream.
- Turns the single-byte core into a multi-byte, chip-select-framed SPI transaction engine.

---
 rtl/spi_xfer_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Transaction sequencer that sits directly in front of a byte-level SPI master
// core. It takes one command (slave index, byte count) and then:
//   * asserts the selected slave-select line;
//   * waits a programmable setup time;
//   * feeds TX bytes to the core one at a time;
//   * returns every received byte on an RX valid/ready stream;
//   * waits a programmable hold time, then releases slave select.
// The result is a multi-byte, chip-select-framed SPI transaction engine built
// on top of a single-byte core.
//
// Parameters
//   NUM_SS    number of slave-select lines (>= 2)
//   LEN_W     width of the byte-count field; a transaction carries
//             cmd_len_i+1 bytes
//   SETUP_CYC clk_i cycles from ss_n assertion to the first core start (>= 1)
//   HOLD_CYC  clk_i cycles from the last core done to ss_n release (>= 1)
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o command handshake; cmd_ss_i, cmd_len_i payload
//   tx_data_i/tx_valid_i/tx_ready_o  TX byte stream into the block
//   rx_data_o/rx_valid_o/rx_ready_i  RX byte stream out of the block
//   core_din_o, core_start_o         byte and start pulse to the SPI core
//   core_ready_i, core_done_i, core_dout_i  status and RX byte from the core
//   ss_n_o                  active-low slave selects (registered)
//   busy_o                  high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module spi_xfer_ctrl #(
  parameter int NUM_SS    = 4,
  parameter int LEN_W     = 8,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // command stream
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [$clog2(NUM_SS)-1:0]   cmd_ss_i,
  input  logic [LEN_W-1:0]            cmd_len_i,
  // TX byte stream
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  // RX byte stream
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  // byte-level SPI core
  output logic [7:0]                  core_din_o,
  output logic                        core_start_o,
  input  logic                        core_ready_i,
  input  logic                        core_done_i,
  input  logic [7:0]                  core_dout_i,
  // slave selects and status
  output logic [NUM_SS-1:0]           ss_n_o,
  output logic                        busy_o
);

  localparam int SS_W    = $clog2(NUM_SS);
  localparam int CYC_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(SETUP_CYC - 1);
  localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT_TX = 3'd2,
    XFER    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t              state_reg,    state_next;
  logic [LEN_W-1:0]    len_reg,      len_next;
  logic [LEN_W-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [CYC_W-1:0]    cyc_cnt_reg,  cyc_cnt_next;
  logic [NUM_SS-1:0]   ss_n_reg,     ss_n_next;
  logic [7:0]          rx_data_reg,  rx_data_next;
  logic                rx_valid_reg, rx_valid_next;

  // One-hot decode of the requested slave. An index >= NUM_SS matches no
  // line, so such a transaction runs with every select left high.
  logic [NUM_SS-1:0]   ss_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
      assign ss_sel[gi] = (cmd_ss_i == SS_W'(gi));
    end
  endgenerate

  // A byte may only be launched when the core is idle and the RX slot is
  // empty; that guarantees the matching core_done always finds room.
  logic tx_ok;
  assign tx_ok = (state_reg == WAIT_TX) & core_ready_i & ~rx_valid_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      cyc_cnt_reg  <= '0;
      ss_n_reg     <= '1;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      ss_n_reg     <= ss_n_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    ss_n_next     = ss_n_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = rx_valid_reg;

    cmd_ready_o   = 1'b0;
    tx_ready_o    = 1'b0;
    core_start_o  = 1'b0;
    core_din_o    = 8'h00;

    // Consumer drain; a core_done in XFER below overrides this (set wins).
    if (rx_valid_reg && rx_ready_i) begin
      rx_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          len_next      = cmd_len_i;
          byte_cnt_next = '0;
          cyc_cnt_next  = '0;
          ss_n_next     = ~ss_sel;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (cyc_cnt_reg == SETUP_LAST) begin
          cyc_cnt_next = '0;
          state_next   = WAIT_TX;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 1'b1;
        end
      end

      WAIT_TX: begin
        tx_ready_o = tx_ok;
        if (tx_valid_i && tx_ok) begin
          core_start_o = 1'b1;
          core_din_o   = tx_data_i;
          state_next   = XFER;
        end
      end

      XFER: begin
        if (core_done_i) begin
          rx_data_next  = core_dout_i;
          rx_valid_next = 1'b1;
          if (byte_cnt_reg == len_reg) begin
            cyc_cnt_next = '0;
            state_next   = HOLD;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
            state_next    = WAIT_TX;
          end
        end
      end

      HOLD: begin
        if (cyc_cnt_reg == HOLD_LAST) begin
          cyc_cnt_next = '0;
          ss_n_next    = '1;
          state_next   = IDLE;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 1'b1;
        end
      end

      default: begin
        ss_n_next  = '1;
        state_next = IDLE;
      end
    endcase
  end

  assign ss_n_o     = ss_n_reg;
  assign rx_data_o  = rx_data_reg;
  assign rx_valid_o = rx_valid_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
//
// Directed testbench for spi_xfer_ctrl. The main instance (NUM_SS=4) is driven
// by a loopback SPI core model; a second instance (NUM_SS=3) exercises the
// out-of-range slave index with hand-driven core signals.
// -----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

  localparam int CORE_LAT = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i = 1'b1;

  // main instance signals
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [1:0] cmd_ss_i = 2'd0;
  logic [7:0] cmd_len_i = 8'd0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b1;
  logic [7:0] core_din_o;
  logic       core_start_o;
  logic       core_ready_i = 1'b1;
  logic       core_done_i = 1'b0;
  logic [7:0] core_dout_i = 8'h00;
  logic [3:0] ss_n_o;
  logic       busy_o;

  // NUM_SS=3 instance signals
  logic       cmd_valid3 = 1'b0;
  logic       cmd_ready3;
  logic [1:0] cmd_ss3 = 2'd0;
  logic [7:0] cmd_len3 = 8'd0;
  logic [7:0] tx_data3 = 8'h00;
  logic       tx_valid3 = 1'b0;
  logic       tx_ready3;
  logic [7:0] rx_data3;
  logic       rx_valid3;
  logic       rx_ready3 = 1'b0;
  logic [7:0] core_din3;
  logic       core_start3;
  logic       core_ready3 = 1'b1;
  logic       core_done3 = 1'b0;
  logic [7:0] core_dout3 = 8'h00;
  logic [2:0] ss_n3;
  logic       busy3;

  spi_xfer_ctrl #(.NUM_SS(4), .LEN_W(8), .SETUP_CYC(4), .HOLD_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_ss_i(cmd_ss_i), .cmd_len_i(cmd_len_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .core_din_o(core_din_o), .core_start_o(core_start_o),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i),
    .core_dout_i(core_dout_i),
    .ss_n_o(ss_n_o), .busy_o(busy_o)
  );

  spi_xfer_ctrl #(.NUM_SS(3), .LEN_W(8), .SETUP_CYC(4), .HOLD_CYC(4)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3),
    .cmd_ss_i(cmd_ss3), .cmd_len_i(cmd_len3),
    .tx_data_i(tx_data3), .tx_valid_i(tx_valid3), .tx_ready_o(tx_ready3),
    .rx_data_o(rx_data3), .rx_valid_o(rx_valid3), .rx_ready_i(rx_ready3),
    .core_din_o(core_din3), .core_start_o(core_start3),
    .core_ready_i(core_ready3), .core_done_i(core_done3),
    .core_dout_i(core_dout3),
    .ss_n_o(ss_n3), .busy_o(busy3)
  );

  int total = 0;
  int bad   = 0;

  // posedge counter: after the k-th rising edge cyc == k
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Loopback core model: a start seen mid-cycle is taken on the next edge,
  // the core goes busy for CORE_LAT cycles, then pulses done returning din.
  // ---------------------------------------------------------------------------
  int         start_cnt   = 0;
  int         done_cnt    = 0;
  int         start_edge  = 0;
  int         done_edge   = 0;
  int         start_rxfull = 0;
  logic [7:0] last_din    = 8'h00;

  always begin
    @(negedge clk_i);
    if (core_start_o === 1'b1 && rst_i === 1'b0) begin
      if (rx_valid_o === 1'b1) start_rxfull = start_rxfull + 1;
      start_cnt  = start_cnt + 1;
      start_edge = cyc + 1;
      last_din   = core_din_o;
      @(posedge clk_i);
      #1 core_ready_i = 1'b0;
      repeat (CORE_LAT) @(posedge clk_i);
      #1;
      core_done_i = 1'b1;
      core_dout_i = last_din;
      done_cnt    = done_cnt + 1;
      done_edge   = cyc + 1;
      @(posedge clk_i);
      #1;
      core_done_i  = 1'b0;
      core_ready_i = 1'b1;
    end
  end

  // RX consumer log: one entry per accepted RX beat
  logic [7:0] rx_q[$];
  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1 && rx_ready_i === 1'b1) rx_q.push_back(rx_data_o);
  end

  // Slave-select continuity monitor
  logic ss_mon_en  = 1'b0;
  int   ss_mon_bit = 0;
  int   ss_viol    = 0;
  always @(negedge clk_i) begin
    if (ss_mon_en && ss_n_o[ss_mon_bit] !== 1'b0) ss_viol <= ss_viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers (all called at #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic [1:0] ss, input logic [7:0] len,
                          output int acc_edge);
    cmd_ss_i    = ss;
    cmd_len_i   = len;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    acc_edge    = cyc;
  endtask

  task automatic push_tx(input logic [7:0] b, input int maxwait);
    logic fire;
    fire       = 1'b0;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    for (int i = 0; i < maxwait && !fire; i++) begin
      @(negedge clk_i);
      fire = (tx_ready_o === 1'b1);
      @(posedge clk_i);
      #1;
    end
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    total++;
    if (!fire) begin
      bad++;
      $display("FAIL tx_accept byte=%02h got=not_taken want=taken within %0d cycles", b, maxwait);
    end
  endtask

  task automatic wait_done(input int target, input int maxwait);
    for (int i = 0; i < maxwait && done_cnt < target; i++) begin
      @(posedge clk_i);
      #1;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL core_done_count got=%0d want=%0d", done_cnt, target);
    end
  endtask

  task automatic wait_idle(input int maxwait);
    for (int i = 0; i < maxwait && busy_o !== 1'b0; i++) begin
      @(posedge clk_i);
      #1;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL return_to_idle busy_o got=%b want=0", busy_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL reset_ss_n got=%b want=1111", ss_n_o); end
    total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid_o); end
    total++; if (rx_data_o !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%02h want=00", rx_data_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready_o); end
    total++; if (tx_ready_o !== 1'b0 || core_start_o !== 1'b0) begin bad++; $display("FAIL idle_handshakes tx_ready=%b core_start=%b want=0,0", tx_ready_o, core_start_o); end
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL idle_ss_n got=%b want=1111", ss_n_o); end
  endtask

  task automatic test_single_byte();
    int acc, s0, d0, rb;
    logic [7:0] got;
    s0 = start_cnt; d0 = done_cnt; rb = rx_q.size();
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL single_cmd_ready got=%b want=1", cmd_ready_o); end
    send_cmd(2'd1, 8'd0, acc);
    total++; if (ss_n_o !== 4'b1101) begin bad++; $display("FAIL single_ss_assert got=%b want=1101", ss_n_o); end
    total++; if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin bad++; $display("FAIL single_busy busy=%b cmd_ready=%b want=1,0", busy_o, cmd_ready_o); end
    push_tx(8'hA5, 20);
    total++; if (start_edge - acc !== 5) begin bad++; $display("FAIL single_setup_latency got=%0d want=5", start_edge - acc); end
    total++; if (last_din !== 8'hA5) begin bad++; $display("FAIL single_core_din got=%02h want=a5", last_din); end
    wait_done(d0 + 1, 40);
    for (int i = 0; i < 20 && cyc < done_edge + 3; i++) begin
      @(posedge clk_i);
      #1;
    end
    total++; if (ss_n_o !== 4'b1101) begin bad++; $display("FAIL single_hold_ss got=%b want=1101", ss_n_o); end
    @(posedge clk_i);
    #1;
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL single_ss_release got=%b want=1111", ss_n_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy_o); end
    got = (rx_q.size() > rb) ? rx_q[rb] : 8'hxx;
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL single_rx got=%02h want=a5", got); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_start_count got=%0d want=1", start_cnt - s0); end
  endtask

  task automatic test_burst();
    int acc, s0, d0, rb, v0;
    logic [7:0] got, exp;
    s0 = start_cnt; d0 = done_cnt; rb = rx_q.size(); v0 = ss_viol;
    send_cmd(2'd0, 8'd3, acc);
    ss_mon_bit = 0;
    ss_mon_en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i + 1);
      push_tx(exp, 40);
    end
    wait_done(d0 + 4, 60);
    ss_mon_en = 1'b0;
    @(posedge clk_i);
    #1;
    total++; if (ss_viol !== v0) begin bad++; $display("FAIL burst_ss_continuous glitches got=%0d want=0", ss_viol - v0); end
    wait_idle(20);
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL burst_ss_release got=%b want=1111", ss_n_o); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i + 1);
      got = (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx;
      total++; if (got !== exp) begin bad++; $display("FAIL burst_rx[%0d] got=%02h want=%02h", i, got, exp); end
    end
    total++; if (start_cnt - s0 !== 4) begin bad++; $display("FAIL burst_start_count got=%0d want=4", start_cnt - s0); end
  endtask

  task automatic test_rx_backpressure();
    int acc, d0, rb, s1, sr, tr_bad;
    logic [7:0] got;
    logic [7:0] exp_q[3];
    exp_q[0] = 8'hB1; exp_q[1] = 8'hB2; exp_q[2] = 8'hB3;
    d0 = done_cnt; rb = rx_q.size(); sr = start_rxfull; tr_bad = 0;
    rx_ready_i = 1'b0;
    send_cmd(2'd2, 8'd2, acc);
    push_tx(8'hB1, 20);
    wait_done(d0 + 1, 40);
    @(posedge clk_i);
    #1;
    total++; if (rx_valid_o !== 1'b1) begin bad++; $display("FAIL bp_rx_valid got=%b want=1", rx_valid_o); end
    s1 = start_cnt;
    tx_data_i  = 8'hB2;
    tx_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tx_ready_o !== 1'b0 || core_start_o !== 1'b0) tr_bad++;
    end
    @(posedge clk_i);
    #1;
    total++; if (tr_bad !== 0) begin bad++; $display("FAIL bp_tx_blocked cycles_with_tx_ready got=%0d want=0", tr_bad); end
    total++; if (start_cnt !== s1) begin bad++; $display("FAIL bp_no_start got=%0d want=%0d", start_cnt, s1); end
    total++; if (rx_data_o !== 8'hB1 || rx_valid_o !== 1'b1) begin bad++; $display("FAIL bp_rx_stable got=%02h/%b want=b1/1", rx_data_o, rx_valid_o); end
    rx_ready_i = 1'b1;
    push_tx(8'hB2, 20);
    push_tx(8'hB3, 40);
    wait_done(d0 + 3, 60);
    wait_idle(20);
    for (int i = 0; i < 3; i++) begin
      got = (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++; $display("FAIL bp_rx[%0d] got=%02h want=%02h", i, got, exp_q[i]); end
    end
    total++; if (start_rxfull !== sr) begin bad++; $display("FAIL bp_start_with_rx_full got=%0d want=0", start_rxfull - sr); end
  endtask

  task automatic test_tx_starvation();
    int acc, d0, rb, v0;
    logic [7:0] got0, got1;
    d0 = done_cnt; rb = rx_q.size(); v0 = ss_viol;
    send_cmd(2'd3, 8'd1, acc);
    ss_mon_bit = 3;
    ss_mon_en  = 1'b1;
    push_tx(8'h11, 20);
    wait_done(d0 + 1, 40);
    repeat (100) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b1 || ss_n_o !== 4'b0111) begin bad++; $display("FAIL starve_hold busy=%b ss_n=%b want=1,0111", busy_o, ss_n_o); end
    total++; if (tx_ready_o !== 1'b1 || core_start_o !== 1'b0) begin bad++; $display("FAIL starve_wait_tx tx_ready=%b start=%b want=1,0", tx_ready_o, core_start_o); end
    push_tx(8'h22, 20);
    wait_done(d0 + 2, 40);
    ss_mon_en = 1'b0;
    @(posedge clk_i);
    #1;
    total++; if (ss_viol !== v0) begin bad++; $display("FAIL starve_ss_continuous glitches got=%0d want=0", ss_viol - v0); end
    wait_idle(20);
    got0 = (rx_q.size() > rb) ? rx_q[rb] : 8'hxx;
    got1 = (rx_q.size() > rb + 1) ? rx_q[rb + 1] : 8'hxx;
    total++; if (got0 !== 8'h11 || got1 !== 8'h22) begin bad++; $display("FAIL starve_rx got=%02h,%02h want=11,22", got0, got1); end
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL starve_ss_release got=%b want=1111", ss_n_o); end
  endtask

  task automatic test_ignored_cmd();
    int acc, s0, d0;
    s0 = start_cnt; d0 = done_cnt;
    send_cmd(2'd1, 8'd0, acc);
    push_tx(8'h77, 20);
    @(posedge clk_i);
    #1;
    cmd_ss_i    = 2'd0;
    cmd_len_i   = 8'd5;
    cmd_valid_i = 1'b1;
    total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL ignored_cmd_ready got=%b want=0", cmd_ready_o); end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    total++; if (ss_n_o !== 4'b1101) begin bad++; $display("FAIL ignored_ss_unchanged got=%b want=1101", ss_n_o); end
    wait_done(d0 + 1, 40);
    wait_idle(20);
    repeat (10) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0 || ss_n_o !== 4'b1111) begin bad++; $display("FAIL ignored_no_new_txn busy=%b ss_n=%b want=0,1111", busy_o, ss_n_o); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL ignored_start_count got=%0d want=1", start_cnt - s0); end
  endtask

  task automatic test_out_of_range();
    logic       got_start;
    logic [7:0] din;
    int         ss_bad;
    got_start = 1'b0; din = 8'h00; ss_bad = 0;
    cmd_ss3    = 2'd3;
    cmd_len3   = 8'd0;
    cmd_valid3 = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid3 = 1'b0;
    total++; if (ss_n3 !== 3'b111 || busy3 !== 1'b1) begin bad++; $display("FAIL oor_accept ss_n=%b busy=%b want=111,1", ss_n3, busy3); end
    tx_data3  = 8'h3C;
    tx_valid3 = 1'b1;
    for (int i = 0; i < 20 && !got_start; i++) begin
      @(negedge clk_i);
      if (ss_n3 !== 3'b111) ss_bad++;
      if (core_start3 === 1'b1) begin
        got_start = 1'b1;
        din = core_din3;
      end
      @(posedge clk_i);
      #1;
    end
    tx_valid3   = 1'b0;
    core_ready3 = 1'b0;
    total++; if (got_start !== 1'b1 || din !== 8'h3C) begin bad++; $display("FAIL oor_start started=%b din=%02h want=1,3c", got_start, din); end
    repeat (3) @(posedge clk_i);
    #1;
    core_done3 = 1'b1;
    core_dout3 = 8'hC3;
    @(posedge clk_i);
    #1;
    core_done3  = 1'b0;
    core_ready3 = 1'b1;
    total++; if (rx_valid3 !== 1'b1 || rx_data3 !== 8'hC3) begin bad++; $display("FAIL oor_rx got=%02h/%b want=c3/1", rx_data3, rx_valid3); end
    rx_ready3 = 1'b1;
    for (int i = 0; i < 20 && busy3 !== 1'b0; i++) begin
      @(negedge clk_i);
      if (ss_n3 !== 3'b111) ss_bad++;
      @(posedge clk_i);
      #1;
    end
    rx_ready3 = 1'b0;
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL oor_idle busy got=%b want=0", busy3); end
    total++; if (ss_bad !== 0) begin bad++; $display("FAIL oor_ss_never_low cycles_low got=%0d want=0", ss_bad); end
  endtask

  task automatic test_reset_mid_transfer();
    int acc, d0, s0, rb;
    logic [7:0] got;
    s0 = start_cnt;
    send_cmd(2'd1, 8'd3, acc);
    push_tx(8'h61, 20);
    push_tx(8'h62, 40);
    @(posedge clk_i);
    #3;
    total++; if (start_cnt - s0 !== 2 || core_ready_i !== 1'b0) begin bad++; $display("FAIL rstmid_in_xfer starts=%0d core_ready=%b want=2,0", start_cnt - s0, core_ready_i); end
    rst_i = 1'b1;
    #1;
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL rstmid_ss_n got=%b want=1111", ss_n_o); end
    total++; if (rx_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_state rx_valid=%b busy=%b want=0,0", rx_valid_o, busy_o); end
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 40 && core_ready_i !== 1'b1; i++) begin
      @(posedge clk_i);
      #1;
    end
    @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_done_ignored busy=%b rx_valid=%b want=0,0", busy_o, rx_valid_o); end
    d0 = done_cnt; rb = rx_q.size();
    send_cmd(2'd2, 8'd0, acc);
    total++; if (ss_n_o !== 4'b1011) begin bad++; $display("FAIL rstmid_new_ss got=%b want=1011", ss_n_o); end
    push_tx(8'h5A, 20);
    wait_done(d0 + 1, 40);
    wait_idle(20);
    got = (rx_q.size() > rb) ? rx_q[rb] : 8'hxx;
    total++; if (got !== 8'h5A) begin bad++; $display("FAIL rstmid_new_rx got=%02h want=5a", got); end
    total++; if (ss_n_o !== 4'b1111) begin bad++; $display("FAIL rstmid_new_release got=%b want=1111", ss_n_o); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_rx_backpressure();
    test_tx_starvation();
    test_ignored_cmd();
    test_out_of_range();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
